// File: rtl/serial_t.sv
// serial_t: 8N1 UART transmitter.
//
// Takes one byte at a time over a valid/ready handshake and sends it on TXD.
// Each frame is one start bit (0), eight data bits LSB first, and one stop
// bit (1). Every bit lasts BAUD_DIV clocks.
//
// A one-entry holding register lets the next byte wait while the current
// frame is sent. With it, back-to-back frames have no idle gap. TXD is
// registered, so the line never glitches.
//
// Parameters:
//   BAUD_DIV  clocks per bit (>= 2)
//   CNT_W     baud counter width, 2**CNT_W > BAUD_DIV
//
// Ports:
//   m_clock   in   system clock, rising edge
//   p_reset   in   synchronous active-high reset
//   tx_valid  in   a byte is offered on tx_data
//   tx_data   in   byte to send, captured only on an accept
//   tx_ready  out  holding register is free, so a byte can be accepted
//   TXD       out  serial line, idles high
//   busy      out  a start, data or stop bit is on the line
module serial_t #(
  parameter int BAUD_DIV = 5208,
  parameter int CNT_W    = 13
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       TXD,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             txd_q, txd_d;

  logic bit_last;
  logic accept;
  logic shifter_free;

  assign bit_last = (cnt_q == CNT_LAST);
  assign accept   = tx_valid && !hold_full_q;

  // The shifter can take a new byte directly when nothing is on the line.
  // It can also take one in the last stop-bit cycle when no byte is held.
  // In that case the new frame starts with no gap.
  assign shifter_free = (state_q == IDLE) ||
                        ((state_q == STOP) && bit_last && !hold_full_q);

  // Next-state logic for the frame sequencer and the holding register.
  // TXD is computed from the next state, so the registered line changes
  // in the same cycle as the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          cnt_d   = '0;
          shift_d = tx_data;
        end
      end
      START: begin
        if (bit_last) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          if (hold_full_q) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            state_d = START;
            shift_d = tx_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // When an accepted byte cannot go straight into the shifter, it waits
    // in the holding register.
    if (accept && !shifter_free) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  // State registers. Reset abandons any partial frame and empties the
  // holding register.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign TXD      = txd_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_t.sv
// Testbench for serial_t with BAUD_DIV=4.
// Every accepted byte is pushed to a scoreboard queue. A line monitor
// decodes TXD, checks that each bit cell is exactly 4 clocks wide, and
// compares each decoded byte with the head of the queue.
module tb_serial_t;

  localparam int BAUD = 4;
  localparam int FRAME = 10 * BAUD;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       TXD;
  logic       busy;

  int check_count = 0;
  int error_count = 0;

  int cycle_num = 0;
  int accept_count = 0;
  int frame_done = 0;
  int busy_count = 0;
  int prev_start = 0;
  int last_start = 0;

  logic [7:0] sb_queue[$];

  logic       in_frame = 1'b0;
  int         sample_idx = 0;
  logic       cell_bad = 1'b0;
  logic [9:0] rx_bits = '0;
  logic [7:0] sb_head;
  int         cell_k;

  serial_t #(.BAUD_DIV(BAUD), .CNT_W(3)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .TXD     (TXD),
    .busy    (busy)
  );

  always #5 m_clock = ~m_clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual,
               expected, cycle_num);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    tx_valid = valid;
    tx_data  = data;
  endtask

  task automatic stepCycle();
    @(posedge m_clock);
    #1;
  endtask

  task automatic waitFrames(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (frame_done >= target) break;
      stepCycle();
    end
    checkOutput("frame_count", frame_done, target);
  endtask

  // Cycle counter, and scoreboard push on every handshake outside reset.
  always @(posedge m_clock) begin
    cycle_num++;
    if (!p_reset && tx_valid && tx_ready) begin
      sb_queue.push_back(tx_data);
      accept_count++;
    end
  end

  // Line monitor that samples on the falling edge.
  always @(negedge m_clock) begin
    if (busy === 1'b1) busy_count++;
    if (p_reset) begin
      in_frame = 1'b0;
      sb_queue.delete();
    end else if (!in_frame) begin
      if (TXD === 1'b0) begin
        in_frame   = 1'b1;
        sample_idx = 1;
        cell_bad   = 1'b0;
        rx_bits[0] = 1'b0;
        prev_start = last_start;
        last_start = cycle_num;
      end
    end else begin
      cell_k = sample_idx / BAUD;
      if ((sample_idx % BAUD) == 0) rx_bits[cell_k] = TXD;
      else if (TXD !== rx_bits[cell_k]) cell_bad = 1'b1;
      sample_idx++;
      if (sample_idx == FRAME) begin
        in_frame = 1'b0;
        checkOutput("bit_cell_width", cell_bad, 0);
        checkOutput("stop_bit", rx_bits[9], 1);
        checkOutput("sb_pending", sb_queue.size() > 0, 1);
        if (sb_queue.size() > 0) begin
          sb_head = sb_queue.pop_front();
          checkOutput("frame_data", rx_bits[8:1], sb_head);
        end
        frame_done++;
      end
    end
  end

  logic ready_bad;
  int   base;

  initial begin
    // Reset held for 3 cycles while a byte is offered.
    applyStimulus(1'b1, 8'h77);
    p_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge m_clock);
      checkOutput("rst_txd", TXD, 1);
      checkOutput("rst_ready", tx_ready, 1);
      checkOutput("rst_busy", busy, 0);
    end
    stepCycle();
    p_reset = 1'b0;
    applyStimulus(1'b0, 8'h77);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("idle_txd", TXD, 1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_no_accept", accept_count, 0);
    checkOutput("idle_no_frame", frame_done, 0);

    // Single frame of 0xA5.
    busy_count = 0;
    base = frame_done;
    applyStimulus(1'b1, 8'hA5);
    checkOutput("pre_accept_txd", TXD, 1);
    stepCycle();
    applyStimulus(1'b0, 8'h00);
    checkOutput("start_latency_txd", TXD, 0);
    checkOutput("start_busy", busy, 1);
    waitFrames(base + 1, 60);
    stepCycle();
    stepCycle();
    checkOutput("single_busy_cycles", busy_count, 40);
    checkOutput("single_end_txd", TXD, 1);
    checkOutput("single_end_busy", busy, 0);

    // Back-to-back frames 0x01 and 0xFF.
    busy_count = 0;
    base = frame_done;
    applyStimulus(1'b1, 8'h01);
    stepCycle();
    applyStimulus(1'b1, 8'hFF);
    stepCycle();
    applyStimulus(1'b0, 8'h00);
    ready_bad = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (tx_ready !== 1'b0) ready_bad = 1'b1;
      stepCycle();
    end
    checkOutput("b2b_ready_low", ready_bad, 0);
    checkOutput("b2b_ready_after_stop", tx_ready, 1);
    waitFrames(base + 2, 100);
    checkOutput("b2b_no_gap", last_start - prev_start, FRAME);
    stepCycle();
    stepCycle();
    checkOutput("b2b_busy_cycles", busy_count, 80);

    // Hold full: a third byte waits until the holding register drains.
    busy_count = 0;
    base = frame_done;
    applyStimulus(1'b1, 8'h01);
    stepCycle();
    applyStimulus(1'b1, 8'hFF);
    stepCycle();
    for (int c = 1; c < 20; c++) begin
      applyStimulus(1'b0, 8'($urandom_range(0, 255)));
      stepCycle();
    end
    checkOutput("hold_no_extra_accept", accept_count, 5);
    applyStimulus(1'b1, 8'h33);
    ready_bad = 1'b0;
    for (int c = 20; c < 40; c++) begin
      if (tx_ready !== 1'b0) ready_bad = 1'b1;
      stepCycle();
    end
    checkOutput("hold_ready_low", ready_bad, 0);
    checkOutput("hold_still_two", accept_count, 5);
    checkOutput("hold_ready_reopens", tx_ready, 1);
    stepCycle();
    applyStimulus(1'b0, 8'h00);
    checkOutput("hold_third_accept", accept_count, 6);
    waitFrames(base + 3, 160);
    stepCycle();
    stepCycle();
    checkOutput("hold_busy_cycles", busy_count, 120);

    // Reset during data bit 3 of 0x00, with tx_valid high in the reset cycle.
    base = frame_done;
    applyStimulus(1'b1, 8'h00);
    stepCycle();
    applyStimulus(1'b0, 8'h00);
    for (int c = 0; c < 17; c++) stepCycle();
    p_reset = 1'b1;
    applyStimulus(1'b1, 8'hEE);
    stepCycle();
    p_reset = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("midrst_txd", TXD, 1);
    checkOutput("midrst_ready", tx_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    for (int c = 0; c < 10; c++) stepCycle();
    checkOutput("midrst_abandoned", frame_done, base);
    checkOutput("midrst_txd_idle", TXD, 1);
    applyStimulus(1'b1, 8'h5A);
    stepCycle();
    applyStimulus(1'b0, 8'h00);
    waitFrames(base + 1, 60);

    for (int c = 0; c < 5; c++) stepCycle();
    checkOutput("sb_drained", sb_queue.size(), 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
